sdram_peek_ctrl: RTL and testbench

//  Command executor downstream of the 64-bit SPI peek/poke slave. Consumes its received word
//  (cmd_in), runs single or burst SDRAM word accesses through a req/ack memory port, and returns
//  a 64-bit status word (status_out) that the slave loads for the next SPI transfer.

---
 rtl/sdram_peek_ctrl_pkg.sv | 61 ++++++
 rtl/sdram_peek_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_sdram_peek_ctrl.sv | 380 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_peek_ctrl_pkg.sv
// Shared opcodes, SPI command/status word layouts and FSM encoding for the SDRAM peek/poke executor.
// The word layouts assume a 24-bit word address and 16-bit data.
package sdram_peek_ctrl_pkg;

    localparam int CMD_ADDR_W = 24;
    localparam int CMD_DATA_W = 16;
    localparam int CNT_W      = 8;
    localparam int TAG_W      = 4;
    localparam int OP_W       = 4;

    localparam logic [OP_W-1:0] OP_NOP    = 4'd0;
    localparam logic [OP_W-1:0] OP_WRITE  = 4'd1;
    localparam logic [OP_W-1:0] OP_READ   = 4'd2;
    localparam logic [OP_W-1:0] OP_FILL   = 4'd3;
    localparam logic [OP_W-1:0] OP_VERIFY = 4'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_NEXT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic [OP_W-1:0]       op;
        logic [TAG_W-1:0]      tag;
        logic [CNT_W-1:0]      cnt;
        logic [CMD_ADDR_W-1:0] addr;
        logic [7:0]            rsvd;
        logic [CMD_DATA_W-1:0] data;
    } cmd_t;

    typedef struct packed {
        logic [OP_W-1:0]       op;
        logic [TAG_W-1:0]      tag;
        logic                  busy;
        logic                  error;
        logic [5:0]            rsvd;
        logic [CMD_ADDR_W-1:0] addr;
        logic [7:0]            err_cnt;
        logic [CMD_DATA_W-1:0] rdata;
    } status_t;

    function automatic logic op_is_mem(input logic [OP_W-1:0] op);
        return (op == OP_WRITE) || (op == OP_READ) || (op == OP_FILL) || (op == OP_VERIFY);
    endfunction

    function automatic logic op_is_write(input logic [OP_W-1:0] op);
        return (op == OP_WRITE) || (op == OP_FILL);
    endfunction

    // Only the burst ops honour the cnt field; single-word ops always run one beat.
    function automatic logic op_is_burst(input logic [OP_W-1:0] op);
        return (op == OP_FILL) || (op == OP_VERIFY);
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sdram_peek_ctrl.sv
// Executes tagged SPI peek/poke words as single/burst SDRAM accesses; accept->first mem_req 2 cycles, DONE->status 1 cycle.
// Memory port holds mem_req until mem_ack; commands arriving while busy are not queued, the newest word wins.
module sdram_peek_ctrl
    import sdram_peek_ctrl_pkg::*;
#(
    parameter int ADDR_BITS = 24,
    parameter int DATA_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [63:0]          cmd_in,
    output logic [63:0]          status_out,
    output logic                 busy,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [DATA_BITS-1:0] mem_wdata,
    input  logic                 mem_ack,
    input  logic [DATA_BITS-1:0] mem_rdata
);

    cmd_t cmd;
    assign cmd = cmd_t'(cmd_in);

    logic unused_rsvd;
    assign unused_rsvd = ^cmd.rsvd;

    state_e               state_q, state_d;
    logic [TAG_W-1:0]     last_tag_q, last_tag_d;
    logic [OP_W-1:0]      op_q, op_d;
    logic [TAG_W-1:0]     tag_q, tag_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     beat_q, beat_d;
    logic [ADDR_BITS-1:0] base_q, base_d;
    logic [DATA_BITS-1:0] pat_q, pat_d;
    logic                 err_q, err_d;
    logic [7:0]           err_cnt_q, err_cnt_d;
    logic [DATA_BITS-1:0] rdata_q, rdata_d;
    logic                 busy_q, busy_d;
    logic                 mem_req_q, mem_req_d;
    logic                 mem_we_q, mem_we_d;
    logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_BITS-1:0] mem_wdata_q, mem_wdata_d;
    status_t              status_q, status_d;
    status_t              status_w;

    logic                 accept;
    logic                 beat_ack;
    logic                 last_beat;
    logic [ADDR_BITS-1:0] beat_addr;
    logic [DATA_BITS-1:0] beat_pat;

    assign accept    = (state_q == ST_IDLE) && (cmd.tag != '0) && (cmd.tag != last_tag_q);
    // An ack only counts once our request is actually visible; a stray ack elsewhere is dropped.
    assign beat_ack  = (state_q == ST_ISSUE) && mem_req_q && mem_ack;
    assign last_beat = (beat_q == cnt_q);
    assign beat_addr = base_q + ADDR_BITS'(beat_q);
    assign beat_pat  = pat_q + DATA_BITS'(beat_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = op_is_mem(cmd.op) ? ST_ISSUE : ST_DONE;
                end
            end
            ST_ISSUE: begin
                if (beat_ack) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT:  state_d = last_beat ? ST_DONE : ST_ISSUE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        last_tag_d  = last_tag_q;
        op_d        = op_q;
        tag_d       = tag_q;
        cnt_d       = cnt_q;
        beat_d      = beat_q;
        base_d      = base_q;
        pat_d       = pat_q;
        err_d       = err_q;
        err_cnt_d   = err_cnt_q;
        rdata_d     = rdata_q;
        busy_d      = busy_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        status_d    = status_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    last_tag_d = cmd.tag;
                    op_d       = cmd.op;
                    tag_d      = cmd.tag;
                    cnt_d      = op_is_burst(cmd.op) ? cmd.cnt : '0;
                    beat_d     = '0;
                    base_d     = cmd.addr;
                    pat_d      = cmd.data;
                    err_d      = !op_is_mem(cmd.op) && (cmd.op != OP_NOP);
                    err_cnt_d  = '0;
                    busy_d     = 1'b1;
                end
            end
            ST_ISSUE: begin
                mem_req_d   = !beat_ack;
                mem_we_d    = op_is_write(op_q);
                mem_addr_d  = beat_addr;
                mem_wdata_d = beat_pat;
                if (beat_ack && !mem_we_q) begin
                    rdata_d = mem_rdata;
                    if ((op_q == OP_VERIFY) && (mem_rdata != beat_pat)) begin
                        err_d     = 1'b1;
                        err_cnt_d = sat_inc8(err_cnt_q);
                    end
                end
            end
            ST_NEXT: begin
                if (!last_beat) begin
                    beat_d = beat_q + 8'd1;
                end
            end
            ST_DONE: begin
                busy_d           = 1'b0;
                status_d.op      = op_q;
                status_d.tag     = tag_q;
                status_d.busy    = 1'b0;
                status_d.error   = err_q;
                status_d.rsvd    = '0;
                status_d.addr    = beat_addr;
                status_d.err_cnt = err_cnt_q;
                status_d.rdata   = rdata_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_tag_q  <= '0;
            op_q        <= '0;
            tag_q       <= '0;
            cnt_q       <= '0;
            beat_q      <= '0;
            base_q      <= '0;
            pat_q       <= '0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            status_q    <= '0;
        end else begin
            last_tag_q  <= last_tag_d;
            op_q        <= op_d;
            tag_q       <= tag_d;
            cnt_q       <= cnt_d;
            beat_q      <= beat_d;
            base_q      <= base_d;
            pat_q       <= pat_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            status_q    <= status_d;
        end
    end

    // The busy bit of the status word follows busy live; everything else is the DONE snapshot.
    always_comb begin
        status_w      = status_q;
        status_w.busy = busy_q;
    end

    assign status_out = status_w;
    assign busy       = busy_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_sdram_peek_ctrl.sv
// Scoreboarded bench for sdram_peek_ctrl: expected memory beats are queued when a command is driven
// and checked by a random-latency memory model as each beat is acknowledged.
module tb_sdram_peek_ctrl;

    typedef struct packed {
        logic        we;
        logic [23:0] addr;
        logic [15:0] wdata;
    } req_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] cmd_in;
    logic [63:0] status_out;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [23:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        ack_m;
    logic        ack_stray;

    assign mem_ack = ack_m | ack_stray;

    always #5 clk = ~clk;

    sdram_peek_ctrl #(.ADDR_BITS(24), .DATA_BITS(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_in     (cmd_in),
        .status_out (status_out),
        .busy       (busy),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    int          total;
    int          bad;
    int          pend;
    int          dly;
    int          ack_count;
    int          ack_limit;
    bit          corrupt_en;
    logic [15:0] mem_arr [int];
    req_t        exp_q[$];
    req_t        held;

    function automatic logic [63:0] mk_cmd(input logic [3:0] op, input logic [3:0] tag,
                                           input logic [7:0] cnt, input logic [23:0] addr,
                                           input logic [15:0] data);
        return {op, tag, cnt, addr, 8'h00, data};
    endfunction

    task automatic push_beats(input logic we, input logic [23:0] addr, input logic [15:0] data,
                              input int n);
        for (int i = 0; i < n; i++) begin
            req_t e;
            e.we    = we;
            e.addr  = addr + 24'(i);
            e.wdata = data + 16'(i);
            exp_q.push_back(e);
        end
    endtask

    // Memory model: acks 0-3 cycles after mem_req is seen, checks each beat against the scoreboard.
    task automatic mem_model();
        forever begin
            @(negedge clk);
            if (ack_m) begin
                ack_m = 1'b0;
            end else if (rst || !mem_req) begin
                pend = 0;
            end else begin
                if (pend == 0) begin
                    pend = 1;
                    dly  = $urandom_range(0, 3);
                    held = '{we: mem_we, addr: mem_addr, wdata: mem_wdata};
                end else begin
                    total++;
                    if ({mem_we, mem_addr, mem_wdata} !== held) begin
                        bad++;
                        $display("FAIL req_stable: we/addr/wdata=%b/%h/%h held %b/%h/%h",
                                 mem_we, mem_addr, mem_wdata, held.we, held.addr, held.wdata);
                    end
                end
                if (ack_count < ack_limit) begin
                    if (dly == 0) begin
                        ack_m = 1'b1;
                        pend  = 0;
                        ack_count++;
                        total++;
                        if (exp_q.size() == 0) begin
                            bad++;
                            $display("FAIL unexpected_req: we=%b addr=%h wdata=%h with empty scoreboard",
                                     mem_we, mem_addr, mem_wdata);
                        end else begin
                            req_t e;
                            e = exp_q.pop_front();
                            if (mem_we !== e.we || mem_addr !== e.addr || (e.we && mem_wdata !== e.wdata)) begin
                                bad++;
                                $display("FAIL beat: got we=%b addr=%h wdata=%h expected we=%b addr=%h wdata=%h",
                                         mem_we, mem_addr, mem_wdata, e.we, e.addr, e.wdata);
                            end
                        end
                        if (mem_we) begin
                            mem_arr[int'(mem_addr)] = mem_wdata;
                        end else begin
                            mem_rdata = mem_arr.exists(int'(mem_addr)) ? mem_arr[int'(mem_addr)] : 16'h0000;
                            if (corrupt_en && mem_addr == 24'h000000) mem_rdata = mem_rdata ^ 16'h8000;
                        end
                    end else begin
                        dly--;
                    end
                end
            end
        end
    endtask

    task automatic wait_done(input logic [3:0] tag, output int reqs);
        bit ok;
        ok   = 0;
        reqs = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (mem_req) reqs++;
            if (!busy && status_out[59:56] == tag) begin
                ok = 1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL done_timeout: tag %0d not reported, status_out=%h", tag, status_out);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cmd_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (status_out !== 64'h0) begin bad++; $display("FAIL reset_status: %h expected 0", status_out); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: %b expected 0", busy); end
        total++;
        if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_req: %b expected 0", mem_req); end
        total++;
        if ({mem_we, mem_addr, mem_wdata} !== 41'h0) begin
            bad++;
            $display("FAIL reset_mem_bus: we=%b addr=%h wdata=%h expected 0", mem_we, mem_addr, mem_wdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_write();
        int reqs;
        push_beats(1'b1, 24'h000100, 16'hBEEF, 1);
        @(negedge clk);
        cmd_in = mk_cmd(4'd1, 4'd1, 8'd0, 24'h000100, 16'hBEEF);
        @(negedge clk);
        total++;
        if (busy !== 1'b1 || mem_req !== 1'b0) begin
            bad++;
            $display("FAIL accept_cycle: busy=%b mem_req=%b expected 1/0", busy, mem_req);
        end
        @(negedge clk);
        total++;
        if (mem_req !== 1'b1) begin bad++; $display("FAIL req_latency: mem_req=%b expected 1", mem_req); end
        wait_done(4'd1, reqs);
        total++;
        if (status_out !== 64'h1100000100000000) begin
            bad++; $display("FAIL write_status: %h expected %h", status_out, 64'h1100000100000000);
        end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL write_beats: %0d left expected 0", exp_q.size()); end
    endtask

    task automatic test_read();
        int reqs;
        push_beats(1'b0, 24'h000100, 16'h0000, 1);
        @(negedge clk);
        cmd_in = mk_cmd(4'd2, 4'd2, 8'd5, 24'h000100, 16'h0000);
        wait_done(4'd2, reqs);
        total++;
        if (status_out !== 64'h220000010000BEEF) begin
            bad++; $display("FAIL read_status: %h expected %h", status_out, 64'h220000010000BEEF);
        end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL read_beats: %0d left expected 0", exp_q.size()); end
    endtask

    task automatic test_fill_wrap();
        int reqs;
        push_beats(1'b1, 24'hFFFFFE, 16'hFFFF, 4);
        @(negedge clk);
        cmd_in = mk_cmd(4'd3, 4'd3, 8'd3, 24'hFFFFFE, 16'hFFFF);
        wait_done(4'd3, reqs);
        total++;
        if (status_out !== 64'h330000000100BEEF) begin
            bad++; $display("FAIL fill_status: %h expected %h", status_out, 64'h330000000100BEEF);
        end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL fill_beats: %0d left expected 0", exp_q.size()); end
        total++;
        if (!mem_arr.exists(0) || mem_arr[0] !== 16'h0001) begin
            bad++; $display("FAIL fill_wrap_word: mem[0] missing or wrong, expected 0001");
        end
    endtask

    task automatic test_verify();
        int reqs;
        corrupt_en = 1'b1;
        push_beats(1'b0, 24'hFFFFFE, 16'hFFFF, 4);
        @(negedge clk);
        cmd_in = mk_cmd(4'd4, 4'd4, 8'd3, 24'hFFFFFE, 16'hFFFF);
        wait_done(4'd4, reqs);
        total++;
        if (status_out !== 64'h4440000001010002) begin
            bad++; $display("FAIL verify_status: %h expected %h", status_out, 64'h4440000001010002);
        end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL verify_beats: %0d left expected 0", exp_q.size()); end
        corrupt_en = 1'b0;
    endtask

    task automatic test_hold_and_tag0();
        int act;
        act = 0;
        repeat (100) begin
            @(negedge clk);
            if (mem_req || busy) act++;
        end
        total++;
        if (act != 0) begin bad++; $display("FAIL same_tag_rerun: %0d active cycles expected 0", act); end
        cmd_in = mk_cmd(4'd1, 4'd0, 8'd0, 24'h000700, 16'h5555);
        act = 0;
        repeat (20) begin
            @(negedge clk);
            if (mem_req || busy) act++;
        end
        total++;
        if (act != 0) begin bad++; $display("FAIL tag0_ignored: %0d active cycles expected 0", act); end
        total++;
        if (status_out !== 64'h4440000001010002) begin
            bad++; $display("FAIL idle_status_hold: %h expected %h", status_out, 64'h4440000001010002);
        end
    endtask

    task automatic test_illegal();
        int reqs;
        @(negedge clk);
        cmd_in = mk_cmd(4'd9, 4'd5, 8'd0, 24'h000000, 16'h0000);
        wait_done(4'd5, reqs);
        total++;
        if (reqs != 0) begin bad++; $display("FAIL illegal_no_req: %0d req cycles expected 0", reqs); end
        total++;
        if (status_out !== 64'h9540000000000002) begin
            bad++; $display("FAIL illegal_status: %h expected %h", status_out, 64'h9540000000000002);
        end
    endtask

    task automatic test_back_to_back();
        int reqs;
        push_beats(1'b1, 24'h000400, 16'h0000, 4);
        push_beats(1'b1, 24'h000300, 16'h1234, 1);
        @(negedge clk);
        cmd_in = mk_cmd(4'd3, 4'd6, 8'd3, 24'h000400, 16'h0000);
        @(negedge clk);
        cmd_in = mk_cmd(4'd2, 4'd7, 8'd0, 24'h000500, 16'h0000);
        repeat (3) @(negedge clk);
        cmd_in = mk_cmd(4'd1, 4'd8, 8'd0, 24'h000300, 16'h1234);
        wait_done(4'd8, reqs);
        total++;
        if (status_out !== 64'h1800000300000002) begin
            bad++; $display("FAIL newest_wins_status: %h expected %h", status_out, 64'h1800000300000002);
        end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL newest_wins_beats: %0d left expected 0", exp_q.size()); end
    endtask

    task automatic test_reset_midburst();
        int  lim;
        int  act;
        int  reqs;
        bit  found;
        push_beats(1'b1, 24'h000200, 16'h1000, 2);
        ack_limit = ack_count + 2;
        lim       = ack_limit;
        @(negedge clk);
        cmd_in = mk_cmd(4'd3, 4'd9, 8'd7, 24'h000200, 16'h1000);
        found = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (mem_req && ack_count == lim) begin
                found = 1;
                break;
            end
        end
        total++;
        if (!found) begin bad++; $display("FAIL beat2_reached: acks=%0d expected %0d with req", ack_count, lim); end
        rst    = 1'b1;
        cmd_in = '0;
        @(negedge clk);
        total++;
        if ({status_out, busy, mem_req, mem_we, mem_addr, mem_wdata} !== 107'h0) begin
            bad++;
            $display("FAIL midburst_reset: status=%h busy=%b req=%b we=%b addr=%h wdata=%h expected all 0",
                     status_out, busy, mem_req, mem_we, mem_addr, mem_wdata);
        end
        rst       = 1'b0;
        ack_limit = 32'h3fffffff;
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL midburst_beats: %0d left expected 0", exp_q.size()); end
        ack_stray = 1'b1;
        @(negedge clk);
        ack_stray = 1'b0;
        act = 0;
        repeat (20) begin
            @(negedge clk);
            if (mem_req || busy) act++;
        end
        total++;
        if (act != 0) begin bad++; $display("FAIL after_reset_idle: %0d active cycles expected 0", act); end
        push_beats(1'b1, 24'h000200, 16'h1000, 8);
        @(negedge clk);
        cmd_in = mk_cmd(4'd3, 4'd9, 8'd7, 24'h000200, 16'h1000);
        wait_done(4'd9, reqs);
        total++;
        if (status_out !== 64'h3900000207000000) begin
            bad++; $display("FAIL rerun_status: %h expected %h", status_out, 64'h3900000207000000);
        end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL rerun_beats: %0d left expected 0", exp_q.size()); end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        pend       = 0;
        dly        = 0;
        ack_count  = 0;
        ack_limit  = 32'h3fffffff;
        corrupt_en = 1'b0;
        ack_m      = 1'b0;
        ack_stray  = 1'b0;
        mem_rdata  = 16'h0000;
        rst        = 1'b1;
        cmd_in     = '0;
        fork
            mem_model();
        join_none
        test_reset();
        test_write();
        test_read();
        test_fill_wrap();
        test_verify();
        test_hold_and_tag0();
        test_illegal();
        test_back_to_back();
        test_reset_midburst();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
